// File: rtl/bcd_digit_counter_bank_pkg.sv
// Shared constants and BCD arithmetic helper for the digit counter bank.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bcd_digit_counter_bank_pkg;

  // Default number of digits in the bank.
  localparam int DIGITS_DEF = 6;

  // Width of one BCD digit.
  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  // Largest legal digit value, and the radix used when a digit wraps.
  localparam bcd_t             BCD_MAX   = 4'd9;
  localparam logic [BCD_W:0]   BCD_RADIX = 5'd10;

  // Result of adding 0..2 to one digit: new value plus carry out.
  typedef struct packed {
    bcd_t val;
    logic carry;
  } bcd_sum_t;

  // Adds inc (0, 1 or 2) to digit d modulo 10 and flags a carry when the sum
  // reaches 10. A digit that is somehow outside 0..9 is pulled back to 0 and
  // produces no carry, so a corrupted digit self-heals on its next add.
  function automatic bcd_sum_t bcd_add(input bcd_t d, input logic [1:0] inc);
    bcd_sum_t        r;
    logic [BCD_W:0]  s;
    r.val   = '0;
    r.carry = 1'b0;
    s       = {1'b0, d} + {{(BCD_W-1){1'b0}}, inc};
    if (d > BCD_MAX) begin
      r.val = '0;
    end else if (s > {1'b0, BCD_MAX}) begin
      s       = s - BCD_RADIX;
      r.val   = s[BCD_W-1:0];
      r.carry = 1'b1;
    end else begin
      r.val = s[BCD_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_counter_bank_digit.sv
// One BCD digit: adds its trigger and incoming carry, registers value and carry out.
// Latency: value and carry update on the edge where an add is requested.
// Backpressure: none; every add request is applied on the edge it is presented.
module bcd_digit
  import bcd_digit_counter_bank_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic add1,
  input  logic add2,
  output bcd_t value,
  output logic carry
);

  logic [1:0] inc;
  bcd_sum_t   nxt;

  // Trigger add and carry add may land on the same edge; both count.
  assign inc = {1'b0, add1} + {1'b0, add2};
  assign nxt = bcd_add(value, inc);

  // Digit register; carry is a one-cycle pulse that lives only after a wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
      carry <= 1'b0;
    end else if (inc != 2'd0) begin
      value <= nxt.val;
      carry <= nxt.carry;
    end else begin
      carry <= 1'b0;
    end
  end

endmodule

// File: rtl/bcd_digit_counter_bank.sv
// Bank of BCD digit counters with ripple carry, display latch and sticky overflow.
// Latency: carry ripples one digit per cycle (DIGITS cycles worst case); display latches on ref_clk.
// Backpressure: none; upstream spaces ref_clk after inc_clk, busy is informational only.
module bcd_digit_counter_bank
  import bcd_digit_counter_bank_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF
)
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DIGITS-1:0]        trigger,
  input  logic                     inc_clk,
  input  logic                     ref_clk,
  output logic [BCD_W*DIGITS-1:0]  digits_out,
  output logic                     ref_valid,
  output logic                     busy,
  output logic                     overflow
);

  // Working count, digit i at [4i+3:4i], and the per-digit carry pipeline.
  logic [BCD_W*DIGITS-1:0] cnt;
  logic [DIGITS-1:0]       carry;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic add1;
    logic add2;

    // Trigger is only looked at on an increment strobe.
    assign add1 = inc_clk & trigger[i];

    // Digit 0 has no carry source; the top digit's carry feeds overflow only.
    if (i == 0) begin : g_lsd
      assign add2 = 1'b0;
    end else begin : g_upper
      assign add2 = carry[i-1];
    end

    bcd_digit u_digit (
      .clk   (clk),
      .reset (reset),
      .add1  (add1),
      .add2  (add2),
      .value (cnt[BCD_W*i +: BCD_W]),
      .carry (carry[i])
    );
  end

  // Carry bits are already flops, so their OR is a clean registered busy.
  assign busy = |carry;

  // Display latch: captures the pre-edge count on refresh, pulses ref_valid after.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits_out <= '0;
      ref_valid  <= 1'b0;
    end else begin
      ref_valid <= ref_clk;
      if (ref_clk) begin
        digits_out <= cnt;
      end
    end
  end

  // Sticky overflow: a carry out of the top digit is dropped and remembered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (carry[DIGITS-1]) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_digit_counter_bank.sv
// Directed bench for the BCD digit counter bank.
// Latency: checks sample on the falling edge after each driven rising edge.
// Backpressure: n/a.
module tb_bcd_digit_counter_bank;

  localparam int N = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  trigger;
  logic          inc_clk;
  logic          ref_clk;
  logic [4*N-1:0] digits_out;
  logic          ref_valid;
  logic          busy;
  logic          overflow;

  int passed = 0;
  int total  = 0;

  bcd_digit_counter_bank #(.DIGITS(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .trigger    (trigger),
    .inc_clk    (inc_clk),
    .ref_clk    (ref_clk),
    .digits_out (digits_out),
    .ref_valid  (ref_valid),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [4*N-1:0] obs, input logic [4*N-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // Drive one rising edge with the given inputs, return at the next falling edge.
  task automatic step(input logic inc, input logic [N-1:0] trig, input logic rf);
    inc_clk = inc;
    trigger = trig;
    ref_clk = rf;
    @(posedge clk);
    @(negedge clk);
    inc_clk = 1'b0;
    trigger = '0;
    ref_clk = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0);
  endtask

  task automatic load(input logic [N-1:0] trig, input int n);
    for (int k = 0; k < n; k++) step(1'b1, trig, 1'b0);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    trigger = '0;
    inc_clk = 1'b0;
    ref_clk = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check_val("rst_digits_out", digits_out, 24'h000000);
    check_bit("rst_ref_valid", ref_valid, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_overflow", overflow, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Five single increments, then refresh
    load(6'b000001, 5);
    check_val("five_no_refresh_yet", digits_out, 24'h000000);
    step(1'b0, '0, 1'b1);
    check_val("five_digits_out", digits_out, 24'h000005);
    check_bit("five_ref_valid_hi", ref_valid, 1'b1);
    idle(1);
    check_bit("five_ref_valid_lo", ref_valid, 1'b0);
    check_val("five_digits_hold", digits_out, 24'h000005);

    // 000099 + 1: two-digit ripple, busy exactly two cycles
    reset_dut();
    load(6'b000011, 9);
    check_bit("r99_idle_busy", busy, 1'b0);
    step(1'b1, 6'b000001, 1'b0);
    check_val("r99_edge0_cnt", dut.cnt, 24'h000090);
    check_bit("r99_edge0_busy", busy, 1'b1);
    idle(1);
    check_val("r99_edge1_cnt", dut.cnt, 24'h000000);
    check_bit("r99_edge1_busy", busy, 1'b1);
    idle(1);
    check_val("r99_edge2_cnt", dut.cnt, 24'h000100);
    check_bit("r99_edge2_busy", busy, 1'b0);
    idle(7);
    step(1'b0, '0, 1'b1);
    check_val("r99_digits_out", digits_out, 24'h000100);
    check_bit("r99_overflow", overflow, 1'b0);

    // 000009 with trigger 000011: digit1 gets trigger add, then carry add
    reset_dut();
    load(6'b000001, 9);
    step(1'b1, 6'b000011, 1'b0);
    check_val("t11_edge0_cnt", dut.cnt, 24'h000010);
    idle(1);
    check_val("t11_edge1_cnt", dut.cnt, 24'h000020);
    check_bit("t11_busy_done", busy, 1'b0);

    // Increment while busy: trigger and carry on digit 1 together, 9+2 wraps
    reset_dut();
    load(6'b000011, 9);
    step(1'b1, 6'b000001, 1'b0);
    step(1'b1, 6'b000010, 1'b0);
    check_val("dbl_edge1_cnt", dut.cnt, 24'h000010);
    check_bit("dbl_edge1_busy", busy, 1'b1);
    idle(1);
    check_val("dbl_edge2_cnt", dut.cnt, 24'h000110);
    check_bit("dbl_edge2_busy", busy, 1'b0);

    // Same-edge increment and refresh at 000042
    reset_dut();
    load(6'b000011, 2);
    load(6'b000010, 2);
    step(1'b1, 6'b000001, 1'b1);
    check_val("same_edge_digits_out", digits_out, 24'h000042);
    check_bit("same_edge_ref_valid", ref_valid, 1'b1);
    step(1'b0, '0, 1'b1);
    check_val("same_edge_next_ref", digits_out, 24'h000043);

    // 999999 + 1: full ripple into overflow
    reset_dut();
    load(6'b111111, 9);
    step(1'b0, '0, 1'b1);
    check_val("ovf_loaded", digits_out, 24'h999999);
    step(1'b1, 6'b000001, 1'b0);
    idle(5);
    check_val("ovf_edge5_cnt", dut.cnt, 24'h000000);
    check_bit("ovf_edge5_overflow", overflow, 1'b0);
    check_bit("ovf_edge5_busy", busy, 1'b1);
    idle(1);
    check_bit("ovf_edge6_overflow", overflow, 1'b1);
    check_bit("ovf_edge6_busy", busy, 1'b0);
    check_val("ovf_no_wrap_into_d0", dut.cnt, 24'h000000);
    load(6'b000001, 3);
    idle(1);
    check_bit("ovf_sticky", overflow, 1'b1);
    check_val("ovf_after_incs", dut.cnt, 24'h000003);

    // Reset mid-ripple on a 5-digit carry chain
    reset_dut();
    load(6'b011111, 9);
    step(1'b0, '0, 1'b1);
    check_val("midrst_loaded", digits_out, 24'h099999);
    step(1'b1, 6'b000001, 1'b0);
    idle(1);
    check_bit("midrst_busy_before", busy, 1'b1);
    reset = 1'b1;
    #1;
    check_val("midrst_digits_out", digits_out, 24'h000000);
    check_val("midrst_cnt", dut.cnt, 24'h000000);
    check_bit("midrst_busy", busy, 1'b0);
    check_bit("midrst_ref_valid", ref_valid, 1'b0);
    check_bit("midrst_overflow", overflow, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    idle(6);
    check_val("midrst_no_residual", dut.cnt, 24'h000000);
    check_bit("midrst_busy_after", busy, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bcd_digit_counter_bank.md
BCD_DIGIT_COUNTER_BANK -- requirements
Module: bcd_digit_counter_bank

Interface
REQ-001 Parameter DIGITS, default 6: number of BCD digits; also the width of the trigger vector.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 trigger  input  DIGITS  per-digit increment request level; bit i selects digit i; bit 0 is the least significant digit.
REQ-005 inc_clk  input  1  one-cycle increment strobe from the trigger counter.
REQ-006 ref_clk  input  1  one-cycle refresh strobe; upstream issues it at least 10 cycles after inc_clk.
REQ-007 digits_out  output  4*DIGITS  latched display value, BCD; digit i occupies bits [4i+3:4i].
REQ-008 ref_valid  output  1  one-cycle pulse, the cycle after digits_out updates.
REQ-009 busy  output  1  high while any carry is pending inside the bank.
REQ-010 overflow  output  1  sticky flag, set on carry out of the most significant digit.

Function
REQ-011 Internal working register cnt holds DIGITS BCD digits; digits_out is a separate display register.
REQ-012 On a clk edge with inc_clk=1, every digit i with trigger[i]=1 adds 1; trigger is sampled only on that edge.
REQ-013 Carries ripple one digit per cycle: a digit wrapping 9->0 on edge t raises carry[i], and digit i+1 adds 1 on edge t+1.
REQ-014 Latency: worst-case ripple is DIGITS cycles after inc_clk, which is below the 10-cycle upstream guard.
REQ-015 Simultaneous trigger add and carry add on one digit in the same edge: digit adds 2 modulo 10 and raises carry if the sum is >=10.
REQ-016 Digit values are always 0..9; a non-BCD value is unreachable, and any such value is forced to 0 on its next add.
REQ-017 A carry out of digit DIGITS-1 sets overflow=1, drops the carry (no wrap into digit 0), and holds overflow until reset.
REQ-018 busy = OR of all pending carry bits, registered; busy=0 whenever no carry is in flight.
REQ-019 On an edge with ref_clk=1, digits_out <= the cnt value present before that edge, regardless of busy; ref_valid=1 on the following cycle only.
REQ-020 inc_clk and ref_clk on the same edge: the refresh captures the pre-increment cnt, and the increment still applies.
REQ-021 inc_clk while busy=1: the new adds and the in-flight carries both apply per REQ-015; nothing is lost.
REQ-022 No state machine beyond the per-digit carry pipeline; the block is otherwise stateless toward upstream (no handshake back).

Reset
REQ-023 reset=1 asynchronously clears cnt, carries, and digits_out to 0; ref_valid=0, busy=0, overflow=0.
REQ-024 Reset mid-ripple discards pending carries; the first edge after release behaves as idle.

Structure
REQ-025 Shared package holds DIGITS default (6), BCD_W=4, and BCD_MAX=9 constants.
REQ-026 One sub-module bcd_digit: inputs add1, add2 (carry), reset, clk; outputs the 4-bit value and a registered carry; instantiated DIGITS times via generate.

Verification
REQ-027 Reset, then inc_clk with trigger=6'b000001 five times, then ref_clk -> digits_out=000005, ref_valid one cycle later.
REQ-028 cnt=000099, inc_clk with trigger=000001 -> digit1 wraps on edge+1 and digit2=1 on edge+2; ref_clk 10 cycles later -> 000100; busy high exactly 2 cycles.
REQ-029 cnt=999999, inc_clk with trigger=000001 -> after 6 cycles cnt=000000 and overflow=1, still 1 after further increments.
REQ-030 cnt=000009, inc_clk with trigger=000011 -> digit1 receives the trigger add then the carry add -> final 000020.
REQ-031 inc_clk and ref_clk on the same edge with cnt=000042 and trigger=000001 -> digits_out=000042; next ref_clk -> 000043.
REQ-032 Assert reset two cycles after an inc that causes a 5-digit ripple -> all outputs 0 immediately; no residual carry after release.
